// File: rtl/bus_terminal_pkg.sv
// Shared constants, types and helpers for the bus terminal endpoint.
package bus_terminal_pkg;

  localparam int          ID_W         = 8;
  localparam logic [7:0]  BCST_DEFAULT = 8'hFF;
  // Widest packet get_dest() can take; packets are zero-extended to this.
  localparam int          MAX_PKT_W    = 256;

  typedef logic [7:0] misroute_cnt_t;

  // Destination ID lives in the top ID_W bits of a pkt_w-bit packet.
  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                input int pkt_w);
    logic [MAX_PKT_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; depth need not be a power of two.
module sync_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             wr_drop
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             wr_ok, rd_ok;

  // Full blocks a write even when a read frees a slot in the same cycle.
  assign wr_ok   = wr && !full;
  assign rd_ok   = rd && !empty;
  assign wr_drop = wr && full;
  assign empty   = (count == '0);
  assign full    = (count == CW'(depth));
  assign rdata   = empty ? '0 : mem[rptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= next_ptr(wptr);
      if (rd_ok) rptr <= next_ptr(rptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are only observed through count.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/bus_terminal.sv
// Device-side endpoint: TX FIFO toward the bus, ID-filtered RX FIFO toward the host.
module bus_terminal
  import bus_terminal_pkg::*;
#(
  parameter int              pckg_sz = 16,
  parameter int              depth   = 8,
  parameter logic [ID_W-1:0] ID      = 8'h00,
  parameter logic [ID_W-1:0] BCST    = BCST_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_push,
  input  logic [pckg_sz-1:0] host_data,
  output logic               host_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_pndng,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_pop,
  output logic               tx_overflow,
  output logic               rx_overflow,
  output misroute_cnt_t      misroute_cnt
);

  logic            tx_empty, tx_drop;
  logic            rx_empty, rx_full, rx_drop;
  logic [ID_W-1:0] dest;
  logic            dest_ok, rx_wr;

  assign dest    = get_dest(MAX_PKT_W'(D_push), pckg_sz);
  assign dest_ok = (dest == ID) || (dest == BCST);
  assign rx_wr   = push && dest_ok;

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr      (host_push),
    .wdata   (host_data),
    .rd      (pop),
    .rdata   (D_pop),
    .empty   (tx_empty),
    .full    (host_full),
    .wr_drop (tx_drop)
  );

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr),
    .wdata   (D_push),
    .rd      (rx_pop),
    .rdata   (rx_data),
    .empty   (rx_empty),
    .full    (rx_full),
    .wr_drop (rx_drop)
  );

  assign pndng    = !tx_empty;
  assign rx_pndng = !rx_empty;

  // Sticky error flags and saturating misroute counter; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_overflow  <= 1'b0;
      rx_overflow  <= 1'b0;
      misroute_cnt <= '0;
    end else begin
      if (tx_drop) tx_overflow <= 1'b1;
      if (rx_drop) rx_overflow <= 1'b1;
      if (push && !dest_ok && misroute_cnt != '1)
        misroute_cnt <= misroute_cnt + 1'b1;
    end
  end

endmodule

// File: doc/bus_terminal.md
Name: bus_terminal

Overview:
Synthesizable device-side endpoint for the bs_gnrtr_n_rbtr bus; it is the terminal end of the pndng/pop/D_pop and push/D_push protocol.
- TX: buffers host packets and presents them to the bus via pndng/D_pop.
- RX: accepts packets pushed by the bus, checks the destination ID, and queues valid ones for the host.
- One instance per bus driver slot. It replaces the behavioural FIFOs the bench drivers emulate today.

Parameters:
pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
depth, 8, entries per FIFO (TX and RX), >=2, need not be a power of two.
ID, 0, 8-bit terminal ID this instance answers to.
BCST, 8'hFF, broadcast ID, accepted by every terminal.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset, sampled on rising edge of clk
host_push  in  1  host writes host_data into TX FIFO
host_data  in  pckg_sz  packet to transmit
host_full  out  1  TX FIFO full
pndng  out  1  TX FIFO non-empty (to bus)
D_pop  out  pckg_sz  TX head packet (to bus)
pop  in  1  bus consumes TX head
push  in  1  bus delivers D_push
D_push  in  pckg_sz  packet from bus
rx_pndng  out  1  RX FIFO non-empty
rx_data  out  pckg_sz  RX head packet
rx_pop  in  1  host consumes RX head
tx_overflow  out  1  sticky: host_push while host_full
rx_overflow  out  1  sticky: valid bus push dropped, RX full
misroute_cnt  out  8  count of pushes with wrong destination, saturates at 255

Behaviour:
Reset (reset==0 at a clk edge), held while low:
- All pointers and counts = 0.
- pndng=0, rx_pndng=0, host_full=0.
- tx_overflow=0, rx_overflow=0, misroute_cnt=0.
- D_pop and rx_data = 0.
- Storage contents are don't-care.
- Reset mid-transfer discards all queued packets. A push or pop in the reset cycle is ignored.

FIFO behaviour (TX and RX identical):
- First-word-fall-through: head data is valid on D_pop / rx_data whenever pndng / rx_pndng = 1.
- Head data is driven to 0 when empty.
- Write latency: an accepted write is visible at the head, with the flag asserted, on the next cycle.
- Pointers wrap from depth-1 to 0.
- Occupancy counter width is $clog2(depth+1). full when count==depth, empty when count==0.

TX rules:
- host_push with host_full=0 writes host_data.
- host_push with host_full=1: data dropped, tx_overflow set. The push is rejected even if pop is asserted in the same cycle.
- pop with pndng=0 is ignored, and no pointer moves.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.

RX rules:
- The bus has no backpressure, so every push is evaluated in the cycle it arrives.
- Destination dest = D_push[pckg_sz-1 -: 8].
- dest==ID or dest==BCST: packet is valid.
  - Valid and RX not full: stored.
  - Valid and RX full: dropped, rx_overflow set. This applies even if rx_pop is asserted in the same cycle.
- Any other dest: packet is not stored. misroute_cnt increments by 1, holding at 255.
- rx_pop with rx_pndng=0 is ignored.
- Simultaneous valid push and rx_pop when not full: count unchanged.

Sticky flags:
- tx_overflow, rx_overflow and misroute_cnt clear only on reset.

Decomposition:
- Package bus_terminal_pkg holds:
  - ID_W=8
  - BCST_DEFAULT=8'hFF
  - function get_dest(pkt), returning the top ID_W bits
  - typedef for the misroute counter
- Sub-module sync_fifo (params width, depth; ports clk, reset, wr, wdata, rd, rdata, empty, full, plus a wr_drop pulse for attempted writes while full).
  - Instantiated twice: TX FIFO and RX FIFO.
  - The ID filter, sticky flags and misroute counter live in bus_terminal.

Test Plan:
1. Reset, then host_push 16'h0312, 16'h0345 on consecutive cycles; bus pops twice -> D_pop shows 16'h0312 one cycle after the first push, then 16'h0345; pndng drops after the second pop.
2. Fill TX with 8 pushes, then 9th push 16'hAAAA with pop=1 same cycle -> host_full=1 before it, 16'hAAAA rejected, tx_overflow=1, 7 entries remain.
3. ID=2: push D_push=16'h0277, then 16'hFF10, then 16'h0599 -> rx_data sequence 16'h0277, 16'hFF10; misroute_cnt=1.
4. ID=2: 9 consecutive valid pushes with no rx_pop -> first 8 stored in order, 9th dropped, rx_overflow=1; draining 8 rx_pops returns all 8 in order, rx_pndng=0.
5. 260 misrouted pushes -> misroute_cnt saturates at 255. Then reset low for one cycle mid-traffic -> all flags, counts and pndng = 0; a push during the reset cycle is not stored.
6. Simultaneous host_push and pop with one entry queued, for 20 cycles -> count stays 1, data order preserved, no overflow.
